// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side signal bundle for mem_port_arbiter.
// slave is the arbiter's view; master is the view of the requesters plus the RAM.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 16
) ();
    logic                  if_req;
    logic [31:0]           if_addr;
    logic                  if_ack;
    logic [31:0]           if_rdata;
    logic                  if_err;

    logic                  mem_req;
    logic                  mem_we;
    logic [1:0]            mem_mode;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;
    logic                  mem_err;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [7:0]            ram_wdata;
    logic [7:0]            ram_rdata;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_mode, mem_addr, mem_wdata, ram_rdata,
        output if_ack, if_rdata, if_err, mem_ack, mem_rdata, mem_err, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_mode, mem_addr, mem_wdata, ram_rdata,
        input  if_ack, if_rdata, if_err, mem_ack, mem_rdata, mem_err, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares a byte-wide single-ported RAM between instruction fetch and the load/store unit,
// sequencing big-endian byte beats and returning assembled, extended read data.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [1:0]            beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  we_q, we_d;
    logic [1:0]            mode_q, mode_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  gnt_mem_q, gnt_mem_d;
    logic                  prio_mem_q, prio_mem_d;
    logic [31:0]           asm_q, asm_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  ram_we_q, ram_we_d;
    logic [7:0]            ram_wdata_q, ram_wdata_d;
    logic                  if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
    logic                  if_err_q, if_err_d, mem_err_q, mem_err_d;
    logic [31:0]           if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;

    logic                  grant_mem;
    logic [31:0]           req_addr;
    logic                  bad_req;
    logic                  finish;
    logic                  fin_err;
    logic [31:0]           rd_val;
    logic [1:0]            last_beat;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{bus.if_addr[31:ADDR_WIDTH], bus.mem_addr[31:ADDR_WIDTH]};
    assign last_beat = (mode_q == 2'b00) ? 2'd3 : 2'd1;

    // Byte for a given beat, most-significant first within the word or half.
    function automatic logic [7:0] beat_byte(input logic [31:0] data, input logic is_word,
                                             input logic [1:0] beat);
        logic [1:0] idx;
        idx = (is_word ? 2'd3 : 2'd1) - beat;
        return data[{idx, 3'b000} +: 8];
    endfunction

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        base_d      = base_q;
        we_d        = we_q;
        mode_d      = mode_q;
        wdata_d     = wdata_q;
        gnt_mem_d   = gnt_mem_q;
        prio_mem_d  = prio_mem_q;
        asm_d       = asm_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_err_d    = 1'b0;
        mem_err_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        grant_mem   = 1'b0;
        req_addr    = '0;
        bad_req     = 1'b0;
        finish      = 1'b0;
        fin_err     = 1'b0;
        rd_val      = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.mem_req || bus.if_req) begin
                    grant_mem  = bus.mem_req && (!bus.if_req || prio_mem_q);
                    gnt_mem_d  = grant_mem;
                    prio_mem_d = !grant_mem;
                    if (grant_mem) begin
                        req_addr = bus.mem_addr;
                        we_d     = bus.mem_we;
                        mode_d   = bus.mem_mode;
                        wdata_d  = bus.mem_wdata;
                    end else begin
                        req_addr = bus.if_addr;
                        we_d     = 1'b0;
                        mode_d   = 2'b00;
                        wdata_d  = '0;
                    end
                    base_d  = req_addr[ADDR_WIDTH-1:0];
                    bad_req = (mode_d == 2'b11)
                            || ((mode_d == 2'b00) && (req_addr[1:0] != 2'b00))
                            || ((mode_d != 2'b00) && req_addr[0]);
                    asm_d   = '0;
                    beat_d  = 2'd0;
                    if (bad_req) begin
                        state_d = StDone;
                        finish  = 1'b1;
                        fin_err = 1'b1;
                    end else begin
                        state_d     = StAccess;
                        ram_addr_d  = base_d;
                        ram_we_d    = we_d;
                        ram_wdata_d = beat_byte(wdata_d, mode_d == 2'b00, 2'd0);
                    end
                end
            end
            StAccess: begin
                // The byte addressed in the previous beat is on ram_rdata now.
                if (!we_q && (beat_q != 2'd0)) begin
                    asm_d = {asm_q[23:0], bus.ram_rdata};
                end
                if (beat_q == last_beat) begin
                    if (we_q) begin
                        state_d = StDone;
                        finish  = 1'b1;
                    end else begin
                        state_d = StDrain;
                    end
                end else begin
                    beat_d      = beat_q + 2'd1;
                    ram_addr_d  = base_q + ADDR_WIDTH'(beat_d);
                    ram_we_d    = we_q;
                    ram_wdata_d = beat_byte(wdata_q, mode_q == 2'b00, beat_d);
                end
            end
            StDrain: begin
                asm_d   = {asm_q[23:0], bus.ram_rdata};
                state_d = StDone;
                finish  = 1'b1;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (finish) begin
            if (fin_err || we_d) begin
                rd_val = '0;
            end else begin
                case (mode_d)
                    2'b01:   rd_val = {{16{asm_d[15]}}, asm_d[15:0]};
                    2'b10:   rd_val = {16'h0000, asm_d[15:0]};
                    default: rd_val = asm_d;
                endcase
            end
            if (gnt_mem_d) begin
                mem_ack_d   = 1'b1;
                mem_err_d   = fin_err;
                mem_rdata_d = rd_val;
            end else begin
                if_ack_d    = 1'b1;
                if_err_d    = fin_err;
                if_rdata_d  = rd_val;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            beat_q      <= 2'd0;
            base_q      <= '0;
            we_q        <= 1'b0;
            mode_q      <= 2'b00;
            wdata_q     <= '0;
            gnt_mem_q   <= 1'b0;
            prio_mem_q  <= 1'b1;
            asm_q       <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_err_q    <= 1'b0;
            mem_err_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            base_q      <= base_d;
            we_q        <= we_d;
            mode_q      <= mode_d;
            wdata_q     <= wdata_d;
            gnt_mem_q   <= gnt_mem_d;
            prio_mem_q  <= prio_mem_d;
            asm_q       <= asm_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_err_q    <= if_err_d;
            mem_err_q   <= mem_err_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.if_err    = if_err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_ack   = mem_ack_q;
    assign bus.mem_err   = mem_err_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_wdata = ram_wdata_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one byte-wide, single-ported data RAM between the IF-stage instruction fetch and the MEM-stage load/store unit.
- Arbitrates between the two requesters and sequences the big-endian byte beats for each access.
- Assembles and extends read data, and holds each requester stalled until its access completes.

Parameters:
ADDR_WIDTH, 16, RAM byte-address width; request addresses are truncated to their low ADDR_WIDTH bits.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
if_req  input  1  instruction fetch request (always a word read); held high until if_ack
if_addr  input  32  fetch byte address
if_ack  output  1  one-cycle pulse: fetch complete, if_rdata valid this cycle
if_rdata  output  32  fetched word
if_err  output  1  with if_ack: misaligned fetch
mem_req  input  1  MEM-stage request; held high until mem_ack
mem_we  input  1  1 = store, 0 = load
mem_mode  input  2  00 word, 01 half signed, 10 half unsigned, 11 illegal
mem_addr  input  32  byte address
mem_wdata  input  32  store data; half stores use bits [15:0]
mem_ack  output  1  one-cycle pulse: access complete
mem_rdata  output  32  load result, valid with mem_ack
mem_err  output  1  with mem_ack: misaligned address or illegal mode
ram_addr  output  ADDR_WIDTH  RAM byte address
ram_we  output  1  RAM byte write enable
ram_wdata  output  8  RAM write byte
ram_rdata  input  8  RAM read byte, valid one cycle after ram_addr is presented

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, reset_n.
- Reset values:
  - if_ack, mem_ack, if_err, mem_err, ram_we all 0.
  - if_rdata, mem_rdata, ram_addr, ram_wdata all 0.
  - State = IDLE.
  - Round-robin pointer favours MEM.
- Reset mid-operation: ram_we drops immediately (asynchronous). The access is abandoned with no ack.
- States: IDLE, ACCESS, DRAIN, DONE.
- IDLE:
  - Sample if_req and mem_req.
  - Both high: grant the requester not granted last; the pointer starts favouring MEM.
  - Only one high: grant it.
  - Latch the granted address, mode, we and wdata.
  - Alignment check: word needs addr[1:0]=00; half needs addr[0]=0; mode 11 is illegal.
  - On violation go to DONE with err=1. No RAM beat is issued.
  - Otherwise go to ACCESS with beat counter = 0. N = 4 for word, 2 for half.
- ACCESS:
  - Each cycle drive ram_addr = base + beat.
  - Stores: ram_we = 1; ram_wdata = latched data, most-significant byte first (word: [31:24] to [7:0]; half: [15:8] then [7:0]).
  - Beat counter increments each cycle. After beat N-1, a store goes to DONE and a load goes to DRAIN.
- Load byte capture: each ram_rdata byte is shifted into the assembly register in the cycle after its address. DRAIN captures the final byte, then goes to DONE.
- DONE:
  - Pulse the granted requester's ack for exactly one cycle, with rdata and err valid.
  - Half signed: rdata = {16 copies of byte0[7], byte0, byte1}. Half unsigned: zero-extended. Word: {b0, b1, b2, b3}.
  - Store ack drives rdata = 0. Error ack drives rdata = 0.
  - Return to IDLE.
- Latency from the IDLE sampling edge to the ack cycle:
  - Word load: 6 cycles. Half load: 4. Word store: 5. Half store: 3. Error: 1.
- rdata holds its value after ack until the next ack to the same requester.
- The ungranted requester keeps waiting. Round robin guarantees it is served next if still requesting.
- Requester obligations:
  - Drop req in the ack cycle. A req still high in the cycle after ack is treated as a new request.
  - Changes to req or request fields during ACCESS/DRAIN are ignored; latched values are used.
- Address wrap: base + beat wraps modulo 2^ADDR_WIDTH.
- ram_we is 0 in IDLE, DRAIN and DONE.

Test Plan:
- Word store then load: MEM store addr 0x10, wdata 0xDEADBEEF -> ram bytes DE,AD,BE,EF at 0x10..0x13, mem_ack 5 cycles after the request; word load of 0x10 -> mem_rdata = 0xDEADBEEF, ack 6 cycles after the request.
- Half loads: bytes 0x80,0x01 at 0x20 -> mode 01 returns 0xFFFF8001; mode 10 returns 0x00008001; each ack 4 cycles after the request.
- Simultaneous requests from reset: if_req and mem_req both high -> MEM served first; IF served next; then with both high again IF precedes... MEM alternation verified over 4 grants; no ack is lost.
- Errors: word load at 0x22, half store at 0x21, or mode 11 -> mem_ack + mem_err on the next cycle, ram_we never asserted, mem_rdata = 0.
- Reset mid-store: assert reset_n low during beat 2 of a word store -> ram_we drops immediately, no ack; after release, state is IDLE and a fresh load completes normally.
- Wrap: ADDR_WIDTH = 16, word store at 0xFFFE with mode word -> mem_err (misaligned); word store at 0xFFFC -> beats at FFFC..FFFF, no spurious beat at 0x0000.
